// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier: operand width,
// iteration count and FSM state encodings.
package shift_add_mult_ctrl_pkg;

    localparam int WIDTH      = 32;
    localparam int CNT_W      = 5;
    localparam int MULT_ITERS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// 32-bit ripple-style adder shared by the multiplier datapath; one pass per
// multiplier bit.
module thirtytwobitadder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'b0, cin};

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 32x32 unsigned shift-and-add multiplier controller (IDLE/RUN/DONE).
// Optional feature macro: ZERO_BYPASS_EN (zero operand skips straight to DONE).
module shift_add_mult_ctrl
    import shift_add_mult_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [1:0]         dbg_state
);

    // Handshake: start is sampled only in IDLE or DONE; busy is high for the
    // 32 RUN cycles; done is a one-cycle pulse and product holds until the
    // next accepted start.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MULT_ITERS - 1);

    mult_state_e          state;
    logic [WIDTH-1:0]     mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     count;

    logic [WIDTH-1:0]     addend;
    logic [WIDTH-1:0]     sum;
    logic                 cout;
    logic [2*WIDTH-1:0]   acc_next;

    assign addend   = acc[0] ? mcand : '0;
    // Carry-out lands in bit 63 so the shifted accumulator never loses a bit.
    assign acc_next = {cout, sum, acc[WIDTH-1:1]};
    assign dbg_state = state;

    thirtytwobitadder u_adder (
        .a    (acc[2*WIDTH-1:WIDTH]),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            count   <= '0;
            mcand   <= '0;
            acc     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
`ifdef ZERO_BYPASS_EN
                        if (a == '0 || b == '0) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            product <= '0;
                        end else begin
                            mcand <= a;
                            acc   <= {{WIDTH{1'b0}}, b};
                            count <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
`else
                        mcand <= a;
                        acc   <= {{WIDTH{1'b0}}, b};
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST_ITER) begin
                        product <= acc_next;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Directed-vector bench for shift_add_mult_ctrl with an expected-product queue
// checked by an independent monitor.
module tb_shift_add_mult_ctrl;
    import shift_add_mult_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_run = 0;
    int cyc;

    logic [63:0] exp_q[$];
    int          exp_busy_q[$];

    shift_add_mult_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic start_op(input logic [31:0] op_a, input logic [31:0] op_b,
                            input logic [63:0] exp_p, input int exp_busy);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        exp_q.push_back(exp_p);
        if (exp_busy > 0) exp_busy_q.push_back(exp_busy);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_done: done not seen within %0d cycles", cycles);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (reset) begin
            busy_run = 0;
        end else begin
            if (done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: product %0h with empty queue", product);
                end else begin
                    check("product", product, exp_q.pop_front());
                end
            end
            if (busy) begin
                busy_run++;
            end else if (busy_run > 0) begin
                if (exp_busy_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_busy: run of %0d cycles", busy_run);
                end else begin
                    check("busy_len", 64'(busy_run), 64'(exp_busy_q.pop_front()));
                end
                busy_run = 0;
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", product, 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 3 x 5, latency and single-cycle done pulse
        start_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 32);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_state", 64'(dbg_state), 64'd1);
        wait_done(cyc);
        check("t1_latency", 64'(cyc), 64'd32);
        @(posedge clk);
        #1;
        check("t1_done_drop", 64'(done), 64'd0);
        check("t1_idle", 64'(dbg_state), 64'd0);
        check("t1_hold", product, 64'h0000_0000_0000_000F);

        // all-ones operands exercise the carry-out path
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 32);
        wait_done(cyc);
        check("t2_latency", 64'(cyc), 64'd32);

        // start during RUN is ignored
        start_op(32'd7, 32'd9, 64'd63, 32);
        repeat (4) @(posedge clk);
        #1;
        a     = 32'd2;
        b     = 32'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("t3_still_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("t3_remaining", 64'(cyc), 64'd27);

        // asynchronous reset mid-RUN discards the operation
        start_op(32'h1234_5678, 32'h10, 64'h0, 32);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        exp_q.delete();
        exp_busy_q.delete();
        #1;
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_done", 64'(done), 64'd0);
        check("t4_product", product, 64'd0);
        check("t4_state", 64'(dbg_state), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        start_op(32'd6, 32'd7, 64'd42, 32);
        wait_done(cyc);

        // start held across the DONE cycle: back-to-back with no idle gap
        a     = 32'd100;
        b     = 32'd200;
        start = 1'b1;
        exp_q.push_back(64'd20000);
        exp_busy_q.push_back(32);
        @(posedge clk);
        #1;
        a = 32'h8000_0000;
        b = 32'd4;
        exp_q.push_back(64'h0000_0002_0000_0000);
        exp_busy_q.push_back(32);
        wait_done(cyc);
        check("t5_first_latency", 64'(cyc), 64'd32);
        @(posedge clk);
        #1 start = 1'b0;
        check("t5_busy_again", 64'(busy), 64'd1);
        check("t5_done_drop", 64'(done), 64'd0);
        wait_done(cyc);
        check("t5_second_latency", 64'(cyc), 64'd32);
        @(posedge clk);
        #1;

        // zero operand
`ifdef ZERO_BYPASS_EN
        start_op(32'd0, 32'h1234, 64'd0, 0);
        check("t6_done_fast", 64'(done), 64'd1);
        check("t6_no_busy", 64'(busy), 64'd0);
        check("t6_product", product, 64'd0);
        @(posedge clk);
        #1;
        check("t6_done_drop", 64'(done), 64'd0);
        check("t6_still_no_busy", 64'(busy), 64'd0);
`else
        start_op(32'd0, 32'h1234, 64'd0, 32);
        check("t6_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("t6_latency", 64'(cyc), 64'd32);
        check("t6_product", product, 64'd0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("exp_busy_q_drained", 64'(exp_busy_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
